// File: rtl/onehot_encoder_seq.sv
// onehot_encoder_seq: sequential 8-to-3 encoder.
// Accepts a multi-hot request vector over valid/ready. For each set bit it
// emits that bit's binary index, one code per output handshake, lowest index
// first.
//
// Ports:
//   clk, rst_n           clock; synchronous active-low reset
//   enable               0 freezes the block: nothing accepted, nothing emitted
//   in_valid/in_ready/in request vector handshake (in_ready is combinational)
//   out_valid/out_ready  code handshake
//   out, out_last        index of the lowest pending bit; set on the final code
//   busy                 a vector is being scanned
//   zero_drop            one-cycle pulse when an all-zero vector is swallowed
module onehot_encoder_seq #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned IDX_W = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             enable,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [IDX_W-1:0] out,
    output logic             out_last,
    output logic             busy,
    output logic             zero_drop
);

    typedef enum logic {
        IDLE = 1'b0,
        SCAN = 1'b1
    } state_t;

    state_t           state, state_nx;
    logic [WIDTH-1:0] pending, pending_nx;
    logic             out_valid_nx;
    logic [IDX_W-1:0] out_nx;
    logic             out_last_nx;
    logic             busy_nx;
    logic             zero_drop_nx;
    logic             fire;

    // Index of the lowest set bit; 0 for an empty vector.
    function automatic logic [IDX_W-1:0] lowest_idx(input logic [WIDTH-1:0] v);
        logic [IDX_W-1:0] idx;
        idx = '0;
        for (int i = int'(WIDTH) - 1; i >= 0; i--) begin
            if (v[i]) idx = IDX_W'(i);
        end
        return idx;
    endfunction

    // True when exactly one bit is set.
    function automatic logic is_single(input logic [WIDTH-1:0] v);
        return (v != '0) && ((v & (v - WIDTH'(1))) == '0);
    endfunction

    assign in_ready = (state == IDLE) & enable & rst_n;

    // Output handshake; ignored while the block is frozen.
    assign fire = (state == SCAN) & out_valid & out_ready & enable;

    // Next-state and registered-output logic.
    always_comb begin
        state_nx     = state;
        pending_nx   = pending;
        out_valid_nx = out_valid;
        zero_drop_nx = 1'b0;

        unique case (state)
            IDLE: begin
                if (in_valid && in_ready) begin
                    if (in != '0) begin
                        pending_nx   = in;
                        state_nx     = SCAN;
                        out_valid_nx = 1'b1;
                    end else begin
                        zero_drop_nx = 1'b1;
                    end
                end
            end
            SCAN: begin
                // Dropping enable only masks out_valid; pending is kept so
                // the same code reappears once enable returns.
                out_valid_nx = enable;
                if (fire) begin
                    pending_nx = pending & (pending - WIDTH'(1));
                    if (out_last) begin
                        state_nx     = IDLE;
                        out_valid_nx = 1'b0;
                    end
                end
            end
        endcase

        // Code outputs track the pending set of the next cycle, so the next
        // code is presented right after a handshake with no bubble.
        out_nx      = lowest_idx(pending_nx);
        out_last_nx = is_single(pending_nx);
        busy_nx     = (state_nx == SCAN);
    end

    // State and output registers.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= IDLE;
            pending   <= '0;
            out_valid <= 1'b0;
            out       <= '0;
            out_last  <= 1'b0;
            busy      <= 1'b0;
            zero_drop <= 1'b0;
        end else begin
            state     <= state_nx;
            pending   <= pending_nx;
            out_valid <= out_valid_nx;
            out       <= out_nx;
            out_last  <= out_last_nx;
            busy      <= busy_nx;
            zero_drop <= zero_drop_nx;
        end
    end

endmodule

// File: tb/tb_onehot_encoder_seq.sv
// Testbench for onehot_encoder_seq: scenario tasks plus a scoreboard of
// expected {code,last} pairs popped on each observed output handshake.
module tb_onehot_encoder_seq;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       enable;
    logic       in_valid;
    logic       in_ready;
    logic [7:0] in;
    logic       out_valid;
    logic       out_ready;
    logic [2:0] out;
    logic       out_last;
    logic       busy;
    logic       zero_drop;

    int passed = 0;
    int total  = 0;

    typedef struct packed {
        logic [2:0] code;
        logic       last;
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;

    always #5 clk = ~clk;

    onehot_encoder_seq dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .enable    (enable),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in        (in),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out       (out),
        .out_last  (out_last),
        .busy      (busy),
        .zero_drop (zero_drop)
    );

    // Output monitor: a handshake happens at the next rising edge when these hold.
    always @(negedge clk) begin
        if (rst_n && enable && out_valid && out_ready) begin
            total++;
            if (sb.size() == 0) begin
                $display("FAIL sb_unexpected: got code=%0d last=%0b, required no code", out, out_last);
            end else begin
                mon_e = sb.pop_front();
                if ({out, out_last} !== {mon_e.code, mon_e.last})
                    $display("FAIL sb_code: got code=%0d last=%0b, required code=%0d last=%0b",
                             out, out_last, mon_e.code, mon_e.last);
                else
                    passed++;
            end
        end
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [2:0] code, input logic last);
        exp_t e;
        e.code = code;
        e.last = last;
        sb.push_back(e);
    endtask

    task automatic accept(input logic [7:0] vec);
        in       = vec;
        in_valid = 1'b1;
        cyc();
        in_valid = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; enable = 1'b0; in_valid = 1'b0; in = 8'h00; out_ready = 1'b0;
        cyc();
        enable = 1'b1;
        cyc();
        total++;
        if ({out_valid, out, out_last, busy, zero_drop} !== 7'd0)
            $display("FAIL reset_outputs: got %b, required 0000000",
                     {out_valid, out, out_last, busy, zero_drop});
        else passed++;
        total++;
        if (in_ready !== 1'b0) $display("FAIL reset_in_ready: got %b, required 0", in_ready);
        else passed++;
        rst_n = 1'b1;
        #1;
        total++;
        if (in_ready !== 1'b1) $display("FAIL post_reset_in_ready: got %b, required 1", in_ready);
        else passed++;
    endtask

    task automatic test_basic();
        int c;
        out_ready = 1'b1;
        push(3'd0, 1'b0); push(3'd2, 1'b0); push(3'd5, 1'b1);
        accept(8'b0010_0101);
        total++;
        if ({out_valid, out, out_last, busy} !== {1'b1, 3'd0, 1'b0, 1'b1})
            $display("FAIL basic_first: got valid=%b out=%0d last=%b busy=%b, required 1 0 0 1",
                     out_valid, out, out_last, busy);
        else passed++;
        // Change the request while busy; it must be ignored.
        in = 8'h81; in_valid = 1'b1;
        total++;
        if (in_ready !== 1'b0) $display("FAIL basic_busy_ready: got %b, required 0", in_ready);
        else passed++;
        c = 0;
        while (out_valid && c < 20) begin
            cyc();
            c++;
        end
        in_valid = 1'b0;
        total++;
        if (c !== 3) $display("FAIL basic_cycles: got %0d, required 3", c);
        else passed++;
        total++;
        if ({in_ready, busy, sb.size() == 0} !== 3'b101)
            $display("FAIL basic_idle: got in_ready=%b busy=%b left=%0d, required 1 0 0",
                     in_ready, busy, sb.size());
        else passed++;
    endtask

    task automatic test_stall();
        logic [2:0] held;
        logic       hold;
        hold = 1'b0;
        held = '0;
        out_ready = 1'b0;
        for (int i = 0; i < 8; i++) push(3'(i), i == 7);
        accept(8'hFF);
        for (int c = 0; c < 40 && (out_valid || sb.size() != 0); c++) begin
            if (hold) begin
                total++;
                if ({out_valid, out} !== {1'b1, held})
                    $display("FAIL stall_hold: got valid=%b out=%0d, required 1 %0d", out_valid, out, held);
                else passed++;
            end
            out_ready = c[0];
            held = out;
            hold = out_valid && !out_ready;
            cyc();
        end
        total++;
        if ({sb.size() == 0, out_valid} !== 2'b10)
            $display("FAIL stall_done: got left=%0d valid=%b, required 0 0", sb.size(), out_valid);
        else passed++;
    endtask

    task automatic test_zero();
        accept(8'h00);
        total++;
        if ({zero_drop, out_valid, in_ready} !== 3'b101)
            $display("FAIL zero_pulse: got drop=%b valid=%b ready=%b, required 1 0 1",
                     zero_drop, out_valid, in_ready);
        else passed++;
        cyc();
        total++;
        if ({zero_drop, out_valid} !== 2'b00)
            $display("FAIL zero_end: got drop=%b valid=%b, required 0 0", zero_drop, out_valid);
        else passed++;
    endtask

    task automatic test_enable();
        out_ready = 1'b1;
        push(3'd3, 1'b0); push(3'd4, 1'b1);
        accept(8'h18);
        cyc();
        enable = 1'b0;
        cyc();
        cyc();
        total++;
        if ({out_valid, out, busy} !== {1'b0, 3'd4, 1'b1})
            $display("FAIL enable_freeze: got valid=%b out=%0d busy=%b, required 0 4 1",
                     out_valid, out, busy);
        else passed++;
        enable = 1'b1;
        cyc();
        total++;
        if ({out_valid, out, out_last} !== {1'b1, 3'd4, 1'b1})
            $display("FAIL enable_resume: got valid=%b out=%0d last=%b, required 1 4 1",
                     out_valid, out, out_last);
        else passed++;
        cyc();
        total++;
        if ({out_valid, sb.size() == 0} !== 2'b01)
            $display("FAIL enable_done: got valid=%b left=%0d, required 0 0", out_valid, sb.size());
        else passed++;
    endtask

    task automatic test_back_to_back();
        int c;
        out_ready = 1'b1;
        push(3'd0, 1'b0); push(3'd1, 1'b1); push(3'd7, 1'b1);
        accept(8'h03);
        in = 8'h80; in_valid = 1'b1;
        c = 0;
        while (!in_ready && c < 20) begin
            cyc();
            c++;
        end
        total++;
        if (c !== 2) $display("FAIL b2b_gap: got %0d cycles, required 2", c);
        else passed++;
        cyc();
        in_valid = 1'b0;
        total++;
        if ({out_valid, out, out_last} !== {1'b1, 3'd7, 1'b1})
            $display("FAIL b2b_single: got valid=%b out=%0d last=%b, required 1 7 1",
                     out_valid, out, out_last);
        else passed++;
        cyc();
        total++;
        if ({out_valid, sb.size() == 0} !== 2'b01)
            $display("FAIL b2b_done: got valid=%b left=%0d, required 0 0", out_valid, sb.size());
        else passed++;
    endtask

    task automatic test_reset_mid();
        out_ready = 1'b1;
        push(3'd4, 1'b0);
        accept(8'hF0);
        cyc();
        // Code 4 has been taken; reset before code 5 can hand off.
        rst_n = 1'b0;
        cyc();
        total++;
        if ({out_valid, busy} !== 2'b00)
            $display("FAIL midreset_outputs: got valid=%b busy=%b, required 0 0", out_valid, busy);
        else passed++;
        rst_n = 1'b1;
        repeat (10) cyc();
        total++;
        if ({out_valid, busy, sb.size() == 0} !== 3'b001)
            $display("FAIL midreset_quiet: got valid=%b busy=%b left=%0d, required 0 0 0",
                     out_valid, busy, sb.size());
        else passed++;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_basic();
        test_stall();
        test_zero();
        test_enable();
        test_back_to_back();
        test_reset_mid();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
